// File: rtl/hex_pkg.sv
// Shared constants for the ASCII-hex receive path: character codes, error codes and FSM states.
package hex_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_TAB   = 8'h09;

    localparam logic [1:0] ERR_BADCHAR  = 2'd0;
    localparam logic [1:0] ERR_ODD      = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } hex_state_t;

endpackage

// File: rtl/hex_rx_parser_ascii_to_nibble.sv
// Combinational ASCII classifier: hex digit value, digit flag and separator flag.
module ascii_to_nibble
    import hex_pkg::*;
(
    input  logic [7:0] in,
    output logic [3:0] nibble,
    output logic       is_digit,
    output logic       is_sep
);

    always_comb begin
        nibble   = 4'd0;
        is_digit = 1'b0;
        is_sep   = 1'b0;
        if (in >= 8'h30 && in <= 8'h39) begin
            nibble   = in[3:0];
            is_digit = 1'b1;
        end else if ((in >= 8'h41 && in <= 8'h46) || (in >= 8'h61 && in <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
            nibble   = in[3:0] + 4'd9;
            is_digit = 1'b1;
        end else begin
            case (in)
                ASCII_SPACE, ASCII_CR, ASCII_LF, ASCII_COMMA, ASCII_TAB: is_sep = 1'b1;
                default: is_sep = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/hex_rx_parser.sv
// ASCII hex text to byte decoder with valid/ready output, separator skipping,
// inter-digit timeout and one-cycle error pulses. All outputs are registered.
//
// state   | meaning
// WAIT_HI | idle, expecting the high digit of the next byte
// WAIT_LO | high digit held, expecting low digit; timeout counter running
module hex_rx_parser
    import hex_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 12_000_000,
    parameter int CNT_W          = 24
) (
    input  logic       CLK,
    input  logic       resetn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       err_valid,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

    hex_state_t       state, state_n;
    logic [3:0]       hi_nib, hi_nib_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             out_valid_n;
    logic [7:0]       out_data_n;
    logic             err_valid_n;
    logic [1:0]       err_code_n;

    logic [3:0] nibble;
    logic       is_digit;
    logic       is_sep;

    ascii_to_nibble u_a2n (
        .in      (in_data),
        .nibble  (nibble),
        .is_digit(is_digit),
        .is_sep  (is_sep)
    );

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state     <= WAIT_HI;
            hi_nib    <= 4'd0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            err_valid <= 1'b0;
            err_code  <= 2'd0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            hi_nib    <= hi_nib_n;
            cnt       <= cnt_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            err_valid <= err_valid_n;
            err_code  <= err_code_n;
            busy      <= (state_n == WAIT_LO);
        end
    end

    always_comb begin
        state_n     = state;
        hi_nib_n    = hi_nib;
        cnt_n       = cnt;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        err_valid_n = 1'b0;
        err_code_n  = err_code;

        if (out_valid && out_ready) begin
            out_valid_n = 1'b0;
        end

        case (state)
            WAIT_HI: begin
                if (in_valid) begin
                    if (is_digit) begin
                        hi_nib_n = nibble;
                        cnt_n    = '0;
                        state_n  = WAIT_LO;
                    end else if (!is_sep) begin
                        err_valid_n = 1'b1;
                        err_code_n  = ERR_BADCHAR;
                    end
                end
            end
            WAIT_LO: begin
                if (in_valid) begin
                    state_n = WAIT_HI;
                    if (is_digit) begin
                        // A completed byte only overflows if the old one is not leaving this edge
                        if (out_valid && !out_ready) begin
                            err_valid_n = 1'b1;
                            err_code_n  = ERR_OVERFLOW;
                        end else begin
                            out_valid_n = 1'b1;
                            out_data_n  = {hi_nib, nibble};
                        end
                    end else begin
                        err_valid_n = 1'b1;
                        err_code_n  = is_sep ? ERR_ODD : ERR_BADCHAR;
                    end
                end else if (TO_EN && cnt == CNT_LAST) begin
                    err_valid_n = 1'b1;
                    err_code_n  = ERR_TIMEOUT;
                    state_n     = WAIT_HI;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = WAIT_HI;
        endcase
    end

endmodule

// File: tb/tb_hex_rx_parser.sv
// Directed and random checks of hex_rx_parser against a per-character reference model.
module tb_hex_rx_parser;

    localparam int TO = 100;

    logic       CLK = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       err_valid;
    logic [1:0] err_code;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int         m_pend = -1;   // pending high digit value, -1 when none
    int         m_idle = 0;    // idle cycles since high digit
    bit         m_ov = 0;
    logic [7:0] m_od = 8'd0;
    bit         m_ev = 0;
    logic [1:0] m_ec = 2'd0;

    string hexchars = "0123456789abcdefABCDEF";
    logic [7:0] seps [5] = '{8'h20, 8'h0D, 8'h0A, 8'h2C, 8'h09};

    hex_rx_parser #(.TIMEOUT_CYCLES(TO), .CNT_W(24)) dut (
        .CLK      (CLK),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .err_valid(err_valid),
        .err_code (err_code),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    // -1 bad, -2 separator, else digit value
    function automatic int classify(input logic [7:0] c);
        int v;
        v = -1;
        if (c >= "0" && c <= "9") v = int'(c) - 48;
        else if (c >= "A" && c <= "F") v = int'(c) - 55;
        else if (c >= "a" && c <= "f") v = int'(c) - 87;
        else if (c == 8'h20 || c == 8'h0D || c == 8'h0A || c == 8'h2C || c == 8'h09) v = -2;
        return v;
    endfunction

    function automatic void raise_err(input logic [1:0] code);
        m_ev = 1;
        m_ec = code;
    endfunction

    task automatic model_edge(input bit rst, input bit v, input logic [7:0] d, input bit r);
        bit old_ov;
        int k;
        if (rst) begin
            m_pend = -1; m_idle = 0; m_ov = 0; m_od = 8'd0; m_ev = 0; m_ec = 2'd0;
            return;
        end
        old_ov = m_ov;
        m_ev = 0;
        if (old_ov && r) m_ov = 0;
        k = classify(d);
        if (m_pend < 0) begin
            if (v) begin
                if (k >= 0) begin m_pend = k; m_idle = 0; end
                else if (k == -1) raise_err(2'd0);
            end
        end else if (v) begin
            if (k >= 0) begin
                if (old_ov && !r) raise_err(2'd3);
                else begin m_od = 8'(m_pend * 16 + k); m_ov = 1; end
            end else if (k == -2) raise_err(2'd1);
            else raise_err(2'd0);
            m_pend = -1;
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                raise_err(2'd2);
                m_pend = -1;
            end
        end
    endtask

    task automatic step(input string tag, input bit rst, input bit v, input logic [7:0] d, input bit r);
        resetn    = !rst;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge CLK);
        model_edge(rst, v, d, r);
        #1;
        n_cmp++;
        assert (out_valid === m_ov) else begin
            n_bad++; $error("FAIL %s out_valid got %0b exp %0b", tag, out_valid, m_ov);
        end
        n_cmp++;
        assert (out_data === m_od) else begin
            n_bad++; $error("FAIL %s out_data got %02h exp %02h", tag, out_data, m_od);
        end
        n_cmp++;
        assert (err_valid === m_ev) else begin
            n_bad++; $error("FAIL %s err_valid got %0b exp %0b", tag, err_valid, m_ev);
        end
        n_cmp++;
        assert (err_code === m_ec) else begin
            n_bad++; $error("FAIL %s err_code got %0d exp %0d", tag, err_code, m_ec);
        end
        n_cmp++;
        assert (busy === (m_pend >= 0)) else begin
            n_bad++; $error("FAIL %s busy got %0b exp %0b", tag, busy, (m_pend >= 0));
        end
    endtask

    task automatic chr(input string tag, input logic [7:0] d, input bit r);
        step(tag, 0, 1, d, r);
    endtask

    task automatic idle(input string tag, input int n, input bit r);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 8'h00, r);
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        step("reset", 1, 0, 8'h00, 0);
        step("reset2", 1, 1, "5", 1);

        // simple byte with consumer ready
        chr("b41_hi", "4", 1); chr("b41_lo", "1", 1); idle("b41_idle", 3, 1);

        // odd digit, held output, separators ignored
        chr("odd_a", "a", 0); chr("odd_sp", " ", 0);
        chr("ff_hi", "F", 0); chr("ff_lo", "f", 0);
        chr("cr", 8'h0D, 0); chr("lf", 8'h0A, 0); idle("hold", 4, 0);
        idle("accept", 2, 1);

        // bad chars in both states
        chr("bad_G", "G", 1); chr("bad_3", "3", 1); chr("bad_z", "z", 1); idle("bad_idle", 2, 1);

        // timeout and resync
        chr("to_hi", "7", 1); idle("to_wait", TO, 1);
        chr("rs_hi", "7", 1); chr("rs_lo", "7", 1); idle("rs_idle", 2, 1);

        // second digit exactly on expiry cycle wins
        chr("exp_hi", "7", 1); idle("exp_wait", TO - 1, 1); chr("exp_lo", "C", 1); idle("exp_idle", 2, 1);

        // overflow, then accept and complete on the same edge
        chr("ov_1", "1", 0); chr("ov_2", "2", 0); chr("ov_3", "3", 0); chr("ov_4", "4", 0);
        chr("ov_5", "5", 0); chr("ov_6", "6", 1); idle("ov_idle", 1, 0); idle("ov_acc", 2, 1);

        // reset with digit and byte pending
        chr("rp_a", "a", 0); chr("rp_b", "b", 0); chr("rp_9", "9", 0);
        step("rp_rst", 1, 0, 8'h00, 0);
        chr("rp_0a", "0", 1); chr("rp_0b", "0", 1); idle("rp_idle", 2, 1);

        // random traffic with occasional long gaps
        for (int i = 0; i < 3000; i++) begin
            int sel;
            logic [7:0] c;
            bit r;
            sel = int'($urandom_range(0, 19));
            r   = ($urandom_range(0, 2) != 0);
            if (sel < 10)      c = 8'(hexchars[int'($urandom_range(0, 21))]);
            else if (sel < 13) c = seps[$urandom_range(0, 4)];
            else               c = 8'($urandom_range(0, 255));
            if (sel == 19 && $urandom_range(0, 3) == 0)
                idle("rnd_gap", int'($urandom_range(TO - 3, TO + 3)), r);
            else
                step("rnd", 0, ($urandom_range(0, 1) == 1), c, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
